reduce_handshake_tx: RTL and testbench

Transmitter side of the ready/valid reduction channel that the RTL monitors check. It accepts pairs of WIDTH-bit words from an upstream producer and buffers them in a DEPTH-entry FIFO. It presents each buffered pair downstream on the `handshake` interface, together with the OR-reduction and AND-reduction flags and the combined `out` bit. The block guarantees the properties the monitor asserts: `out === temp1 && temp2` whenever `handshake_valid` is high, and valid/payload stability until the transfer completes.

---
 rtl/reduce_handshake_tx.sv | 95 +++++++++
 tb/tb_reduce_handshake_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reduce_handshake_tx.sv
// Transmit side of the ready/valid reduction channel: buffers input pairs in a FIFO
// and presents the head pair with its OR/AND reduction flags, computed at enqueue.
module reduce_handshake_tx #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in1,
  input  logic [WIDTH-1:0]           in2,
  output logic                       handshake_valid,
  input  logic                       handshake_ready,
  output logic [WIDTH-1:0]           out_in1,
  output logic [WIDTH-1:0]           out_in2,
  output logic                       mon_temp1,
  output logic                       mon_temp2,
  output logic                       out,
  output logic [CNT_W-1:0]           xfer_count,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * WIDTH + 2;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Handshake: a transfer happens on a rising CLK edge where valid and ready are both
  // high; valid and payload hold steady until then, and valid never looks at ready.
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_xfer_count;

  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_valid    = (r_occ != '0);
  assign w_pop      = w_valid & handshake_ready;
  assign in_ready   = (r_occ != OCC_FULL) | w_pop;
  assign w_push     = in_valid & in_ready;
  // Entry layout: {or_flag, and_flag, word2, word1}; both flags reduce word 1.
  assign w_wr_entry = {|in1, &in1, in2, in1};

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_xfer_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PTR_ONE;
        r_xfer_count <= r_xfer_count + CNT_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Masking the head with valid keeps the payload at zero while empty, so the
  // unreset storage array never leaks onto the outputs.
  assign w_head          = w_valid ? r_mem[r_rd_ptr] : '0;
  assign handshake_valid = w_valid;
  assign out_in1         = w_head[WIDTH-1:0];
  assign out_in2         = w_head[2*WIDTH-1:WIDTH];
  assign mon_temp2       = w_head[2*WIDTH];
  assign mon_temp1       = w_head[2*WIDTH+1];
  assign out             = mon_temp1 & mon_temp2;
  assign xfer_count      = r_xfer_count;
  assign occupancy       = r_occ;

endmodule

// File: tb/tb_reduce_handshake_tx.sv
// Randomized and directed bench for reduce_handshake_tx against a queue-based model;
// a second instance with a 4-bit counter shares all inputs to cover counter wrap.
module tb_reduce_handshake_tx;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;

  logic             CLK;
  logic             RESET;
  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             handshake_ready;

  logic             in_ready, handshake_valid, mon_temp1, mon_temp2, out;
  logic [WIDTH-1:0] out_in1, out_in2;
  logic [15:0]      xfer_count;
  logic [2:0]       occupancy;

  logic             in_ready4, handshake_valid4, mon_temp1_4, mon_temp2_4, out4;
  logic [WIDTH-1:0] out_in1_4, out_in2_4;
  logic [3:0]       xfer_count4;
  logic [2:0]       occupancy4;

  reduce_handshake_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .handshake_valid(handshake_valid),
    .handshake_ready(handshake_ready), .out_in1(out_in1), .out_in2(out_in2),
    .mon_temp1(mon_temp1), .mon_temp2(mon_temp2), .out(out),
    .xfer_count(xfer_count), .occupancy(occupancy)
  );

  reduce_handshake_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready4),
    .in1(in1), .in2(in2), .handshake_valid(handshake_valid4),
    .handshake_ready(handshake_ready), .out_in1(out_in1_4), .out_in2(out_in2_4),
    .mon_temp1(mon_temp1_4), .mon_temp2(mon_temp2_4), .out(out4),
    .xfer_count(xfer_count4), .occupancy(occupancy4)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  // scoreboard: expected queue of {in1, in2} pairs and a transfer tally
  logic [2*WIDTH-1:0] exp_q[$];
  int unsigned        m_xfer;
  int                 n_vec;
  int                 n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic rdy);
    logic             e_valid;
    logic             e_ready;
    logic [WIDTH-1:0] h1;
    logic [WIDTH-1:0] h2;
    e_valid = (exp_q.size() != 0);
    e_ready = (exp_q.size() != DEPTH) || (e_valid && rdy);
    check("valid", 32'(handshake_valid), 32'(e_valid));
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("occupancy", 32'(occupancy), 32'(exp_q.size()));
    check("xfer_count", 32'(xfer_count), m_xfer % 65536);
    check("xfer_count4", 32'(xfer_count4), m_xfer % 16);
    if (e_valid) begin
      {h1, h2} = exp_q[0];
      check("out_in1", 32'(out_in1), 32'(h1));
      check("out_in2", 32'(out_in2), 32'(h2));
      check("mon_temp1", 32'(mon_temp1), 32'(h1 != 0));
      check("mon_temp2", 32'(mon_temp2), 32'(h1 == '1));
      check("out", 32'(out), 32'((h1 != 0) && (h1 == '1)));
    end
  endtask

  // driver: one cycle of stimulus, checked before the edge, model updated at the edge
  task automatic step(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic rdy, input logic rst, output logic accepted);
    logic pop;
    in_valid        = iv;
    in1             = a;
    in2             = b;
    handshake_ready = rdy;
    RESET           = rst;
    #1;
    check_outputs(rdy);
    pop      = (exp_q.size() != 0) && rdy;
    accepted = iv && ((exp_q.size() != DEPTH) || pop);
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
      m_xfer = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_xfer++;
      end
      if (accepted) exp_q.push_back({a, b});
    end
    @(negedge CLK);
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    step(1'b0, '0, '0, rdy, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    check("drained", 32'(exp_q.size()), 32'd0);
    idle(1'b1);
  endtask

  initial begin
    logic acc;
    logic pending;
    logic [WIDTH-1:0] a, b;
    int unsigned base;
    int pushed;
    n_vec = 0; n_err = 0; m_xfer = 0;
    in_valid = 1'b0; in1 = '0; in2 = '0; handshake_ready = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // reset values
    RESET = 1'b0;
    #1;
    check("rst_valid", 32'(handshake_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_payload", 32'({out_in1, out_in2, mon_temp1, mon_temp2, out}), 32'd0);
    @(negedge CLK);

    // single pair, ready high
    step(1'b1, 5'b11111, 5'b00011, 1'b1, 1'b0, acc);
    check("single_accept", 32'(acc), 32'd1);
    idle(1'b1);
    idle(1'b1);
    check("single_xfer", 32'(xfer_count), 32'd1);

    // reduction patterns back to back
    step(1'b1, 5'b00000, 5'b01010, 1'b1, 1'b0, acc);
    step(1'b1, 5'b10100, 5'b00001, 1'b1, 1'b0, acc);
    step(1'b1, 5'b11111, 5'b10000, 1'b1, 1'b0, acc);
    drain();

    // fill with ready low, then a simultaneous dequeue/enqueue on a full FIFO
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(i + 3), WIDTH'(i + 20), 1'b0, 1'b0, acc);
    step(1'b1, 5'b01111, 5'b11110, 1'b0, 1'b0, acc);
    check("full_blocks", 32'(acc), 32'd0);
    check("full_occ", 32'(occupancy), 32'd4);
    step(1'b1, 5'b01111, 5'b11110, 1'b1, 1'b0, acc);
    check("full_swap_accept", 32'(acc), 32'd1);
    check("full_swap_occ", 32'(occupancy), 32'd4);
    drain();

    // reset with three buffered entries and ready high
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(i + 9), WIDTH'(i + 1), 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_valid", 32'(handshake_valid), 32'd0);
    check("midrst_xfer", 32'(xfer_count), 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // seventeen transfers wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, acc);
    drain();
    check("wrap17_cnt4", 32'(xfer_count4), 32'd1);
    check("wrap17_cnt16", 32'(xfer_count), 32'd17);

    // random stalls over 200 pairs; an unaccepted offer is held unchanged
    base = m_xfer;
    pushed = 0;
    pending = 1'b0;
    a = '0; b = '0;
    for (int cyc = 0; cyc < 4000 && pushed < 200; cyc++) begin
      if (!pending) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      if (pending || $urandom_range(0, 3) != 0) begin
        step(1'b1, a, b, 1'($urandom_range(0, 1)), 1'b0, acc);
        pending = !acc;
        if (acc) pushed++;
      end else begin
        idle(1'($urandom_range(0, 1)));
      end
    end
    drain();
    check("random_pushed", 32'(pushed), 32'd200);
    check("random_xfer", 32'(xfer_count), (base + 200) % 65536);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
